// File: rtl/iou_pkg.sv
// Shared IOU definitions: register byte addresses and CTRL/STATUS bit layout
// for the display data controller.
package iou_pkg;

   localparam logic [7:0] DISP_DATA_ADDR   = 8'h00;
   localparam logic [7:0] DISP_CTRL_ADDR   = 8'h04;
   localparam logic [7:0] DISP_STATUS_ADDR = 8'h08;

   localparam int CTRL_ENTRY_BIT  = 0;
   localparam int STATUS_DONE_BIT = 0;
   localparam int STATUS_CNT_LSB  = 4;
   localparam int STATUS_CNT_W    = 3;

   // Pack DONE flag and digit count into the STATUS read word.
   function automatic logic [31:0] status_word(input logic done, input logic [STATUS_CNT_W-1:0] cnt);
      status_word = '0;
      status_word[STATUS_DONE_BIT] = done;
      status_word[STATUS_CNT_LSB +: STATUS_CNT_W] = cnt;
   endfunction

endpackage

// File: rtl/disp_data_ctrl_if.sv
// CPU I/O bus seen by the display data controller. The CPU side is the
// master; the register block is the slave and returns registered read data.
interface disp_data_ctrl_if;
   logic        io_we;
   logic        io_re;
   logic [7:0]  io_addr;
   logic [31:0] io_wdata;
   logic [31:0] io_rdata;

   modport master (output io_we, output io_re, output io_addr, output io_wdata, input io_rdata);
   modport slave  (input io_we, input io_re, input io_addr, input io_wdata, output io_rdata);
endinterface

// File: rtl/disp_data_ctrl_debounce.sv
// btn_debounce: 2-FF synchroniser, down-counter debouncer and rising-edge
// press pulse. The debounced level follows the synchronised button only
// after it has differed from it for DB_CYCLES consecutive cycles; any return
// to the debounced level reloads the counter.
module btn_debounce #(
   parameter logic [19:0] DB_CYCLES = 20'd1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_press
);

   localparam logic [19:0] LP_RELOAD = DB_CYCLES - 20'd1;

   logic        r_sync1;
   logic        r_sync2;
   logic        r_level;
   logic        r_press;
   logic [19:0] r_cnt;

   // Synchronise, count the stable interval and emit a one-cycle press pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= LP_RELOAD;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= LP_RELOAD;
         end else if (r_cnt == 20'd0) begin
            r_level <= r_sync2;
            r_press <= r_sync2;
            r_cnt   <= LP_RELOAD;
         end else begin
            r_cnt <= r_cnt - 20'd1;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/disp_data_ctrl.sv
// disp_data_ctrl: memory-mapped source of the 32-bit word on the 7-segment
// scanner. DATA is bus read/write; with DISP_ENTRY_EN defined, a debounced
// button shifts switch digits into DATA while CTRL.ENTRY is set, and STATUS
// reports the digit count and an 8-digit DONE flag (cleared by reading it).
// Without DISP_ENTRY_EN, sw/btn are ignored and CTRL/STATUS read as zero.
module disp_data_ctrl
   import iou_pkg::*;
#(
   parameter logic [19:0] DB_CYCLES = 20'd1000000,
   parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   disp_data_ctrl_if.slave   bus,
   input  logic [3:0]        sw,
   input  logic              btn,
   output logic [31:0]       disp_data
);

   logic        w_wr_data;
   logic        w_wr_ctrl;
   logic        w_rd_status;
   logic        w_shift;
   logic [31:0] w_ctrl_val;
   logic [31:0] w_status_val;
   logic [31:0] w_rd_val;
   logic [31:0] r_data;
   logic [31:0] r_rdata;

   assign w_wr_data   = bus.io_we && (bus.io_addr == DISP_DATA_ADDR);
   assign w_wr_ctrl   = bus.io_we && (bus.io_addr == DISP_CTRL_ADDR);
   assign w_rd_status = bus.io_re && (bus.io_addr == DISP_STATUS_ADDR);

`ifdef DISP_ENTRY_EN
   logic                    w_press;
   logic                    r_entry;
   logic                    r_done;
   logic [STATUS_CNT_W-1:0] r_count;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btn),
      .o_press (w_press)
   );

   assign w_shift      = w_press && r_entry;
   assign w_ctrl_val   = 32'(r_entry) << CTRL_ENTRY_BIT;
   assign w_status_val = status_word(r_done, r_count);

   // Entry control: CTRL write restarts the digit count; a colliding DATA
   // write discards the shift and clears the count; the 8th digit sets DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_entry <= 1'b0;
         r_done  <= 1'b0;
         r_count <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_entry <= bus.io_wdata[CTRL_ENTRY_BIT];
            r_count <= '0;
         end else if (w_shift) begin
            r_count <= w_wr_data ? '0 : r_count + 1'b1;
         end
         if (w_shift && !w_wr_data && !w_wr_ctrl && (r_count == 3'd7)) begin
            r_done <= 1'b1;
         end else if (w_rd_status) begin
            r_done <= 1'b0;
         end
      end
   end
`else
   logic w_unused;

   assign w_shift      = 1'b0;
   assign w_ctrl_val   = '0;
   assign w_status_val = '0;
   assign w_unused     = ^{sw, btn, w_wr_ctrl, w_rd_status, DB_CYCLES};
`endif

   // Read mux over the pre-write register values.
   always_comb begin
      w_rd_val = '0;
      case (bus.io_addr)
         DISP_DATA_ADDR:   w_rd_val = r_data;
         DISP_CTRL_ADDR:   w_rd_val = w_ctrl_val;
         DISP_STATUS_ADDR: w_rd_val = w_status_val;
         default:          w_rd_val = '0;
      endcase
   end

   // DATA register (bus write beats a digit shift) and registered read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= RESET_VAL;
         r_rdata <= '0;
      end else begin
         if (w_wr_data) begin
            r_data <= bus.io_wdata;
         end else if (w_shift) begin
            r_data <= {r_data[27:0], sw};
         end
         if (bus.io_re) begin
            r_rdata <= w_rd_val;
         end
      end
   end

   assign bus.io_rdata = r_rdata;
   assign disp_data    = r_data;

endmodule

// File: tb/tb_disp_data_ctrl.sv
// Self-checking bench for disp_data_ctrl with DB_CYCLES=4. Entry-mode
// scenarios run when DISP_ENTRY_EN is defined; otherwise the bench checks
// that sw/btn are ignored and CTRL/STATUS read zero.
module tb_disp_data_ctrl;

   localparam logic [19:0] DB = 20'd4;
   localparam int          DBI = 4;

   logic        clk;
   logic        rst;
   logic [3:0]  sw;
   logic        btn;
   logic [31:0] disp_data;

   disp_data_ctrl_if u_bus ();

   disp_data_ctrl #(.DB_CYCLES(DB), .RESET_VAL(32'h0000_0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (u_bus),
      .sw        (sw),
      .btn       (btn),
      .disp_data (disp_data)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] m_data;
   logic        m_entry;
   int          m_count;
   logic        m_done;
   logic [31:0] m_rdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] addr);
      logic [31:0] v;
      v = 32'h0;
      if (addr == 8'h00) v = m_data;
`ifdef DISP_ENTRY_EN
      if (addr == 8'h04) v = {31'h0, m_entry};
      if (addr == 8'h08) v = (32'(m_count % 8) << 4) | {31'h0, m_done};
`endif
      return v;
   endfunction

   task automatic model_reset();
      m_data  = 32'h0;
      m_entry = 1'b0;
      m_count = 0;
      m_done  = 1'b0;
      m_rdata = 32'h0;
   endtask

   task automatic model_press(input logic [3:0] digit);
`ifdef DISP_ENTRY_EN
      if (m_entry) begin
         m_data  = (m_data << 4) | 32'(digit);
         m_count = m_count + 1;
         if (m_count == 8) begin
            m_count = 0;
            m_done  = 1'b1;
         end
      end
`endif
   endtask

   // One bus cycle; model updated with read-before-write ordering.
   task automatic bus_op(input logic we, input logic re, input logic [7:0] addr, input logic [31:0] wd);
      logic [31:0] exp_rd;
      exp_rd = model_read(addr);
      u_bus.io_we    = we;
      u_bus.io_re    = re;
      u_bus.io_addr  = addr;
      u_bus.io_wdata = wd;
      cyc();
      u_bus.io_we = 1'b0;
      u_bus.io_re = 1'b0;
      if (re) begin
         m_rdata = exp_rd;
`ifdef DISP_ENTRY_EN
         if (addr == 8'h08) m_done = 1'b0;
`endif
      end
      if (we) begin
         if (addr == 8'h00) m_data = wd;
`ifdef DISP_ENTRY_EN
         if (addr == 8'h04) begin
            m_entry = wd[0];
            m_count = 0;
         end
`endif
      end
   endtask

   task automatic clean_press(input logic [3:0] digit);
      sw  = digit;
      btn = 1'b1;
      repeat (DBI + 8) cyc();
      btn = 1'b0;
      repeat (DBI + 8) cyc();
      model_press(digit);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn = 1'b0;
      sw  = 4'h0;
      u_bus.io_we = 1'b0; u_bus.io_re = 1'b0; u_bus.io_addr = 8'h00; u_bus.io_wdata = 32'h0;
      model_reset();
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      n_cmp++;
      if (disp_data !== 32'h0) begin n_err++; $display("FAIL reset_disp: got %h expected %h", disp_data, 32'h0); end
      n_cmp++;
      if (u_bus.io_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected %h", u_bus.io_rdata, 32'h0); end
      bus_op(1'b0, 1'b1, 8'h08, 32'h0);
      n_cmp++;
      if (u_bus.io_rdata !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h expected %h", u_bus.io_rdata, 32'h0); end
   endtask

   task automatic test_bus();
      bus_op(1'b1, 1'b0, 8'h00, 32'h1234_ABCD);
      n_cmp++;
      if (disp_data !== 32'h1234_ABCD) begin n_err++; $display("FAIL bus_write: got %h expected %h", disp_data, 32'h1234_ABCD); end
      bus_op(1'b0, 1'b1, 8'h00, 32'h0);
      n_cmp++;
      if (u_bus.io_rdata !== 32'h1234_ABCD) begin n_err++; $display("FAIL bus_read: got %h expected %h", u_bus.io_rdata, 32'h1234_ABCD); end
   endtask

   task automatic test_random_bus();
      logic [7:0]  a;
      logic        we;
      logic        re;
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 3))
            0: a = 8'h00;
            1: a = 8'h04;
            2: a = 8'h08;
            default: a = 8'($urandom);
         endcase
         we = 1'($urandom);
         re = 1'($urandom);
         bus_op(we, re, a, $urandom);
         n_cmp++;
         if (u_bus.io_rdata !== m_rdata) begin n_err++; $display("FAIL rand_rdata[%0d] addr %h: got %h expected %h", i, a, u_bus.io_rdata, m_rdata); end
         n_cmp++;
         if (disp_data !== m_data) begin n_err++; $display("FAIL rand_disp[%0d]: got %h expected %h", i, disp_data, m_data); end
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] old;
      bus_op(1'b1, 1'b0, 8'h00, 32'hCAFE_0001);
      old = m_data;
      bus_op(1'b1, 1'b1, 8'h00, 32'h5A5A_A5A5);
      n_cmp++;
      if (u_bus.io_rdata !== old) begin n_err++; $display("FAIL simul_rdata: got %h expected %h", u_bus.io_rdata, old); end
      n_cmp++;
      if (disp_data !== 32'h5A5A_A5A5) begin n_err++; $display("FAIL simul_disp: got %h expected %h", disp_data, 32'h5A5A_A5A5); end
   endtask

   task automatic test_ignore();
`ifdef DISP_ENTRY_EN
      bus_op(1'b1, 1'b0, 8'h04, 32'h0);
`else
      bus_op(1'b1, 1'b0, 8'h04, 32'h1);
`endif
      for (int i = 0; i < 3; i++) clean_press(4'($urandom_range(1, 15)));
      n_cmp++;
      if (disp_data !== m_data) begin n_err++; $display("FAIL ignore_disp: got %h expected %h", disp_data, m_data); end
      bus_op(1'b0, 1'b1, 8'h04, 32'h0);
      n_cmp++;
      if (u_bus.io_rdata !== m_rdata) begin n_err++; $display("FAIL ignore_ctrl: got %h expected %h", u_bus.io_rdata, m_rdata); end
      bus_op(1'b0, 1'b1, 8'h08, 32'h0);
      n_cmp++;
      if (u_bus.io_rdata !== m_rdata) begin n_err++; $display("FAIL ignore_status: got %h expected %h", u_bus.io_rdata, m_rdata); end
   endtask

`ifdef DISP_ENTRY_EN
   task automatic test_entry();
      bus_op(1'b1, 1'b0, 8'h04, 32'h1);
      for (int i = 1; i <= 8; i++) begin
         clean_press(4'(i));
         n_cmp++;
         if (disp_data !== m_data) begin n_err++; $display("FAIL entry_digit%0d: got %h expected %h", i, disp_data, m_data); end
         if (i == 3) begin
            bus_op(1'b0, 1'b1, 8'h08, 32'h0);
            n_cmp++;
            if (u_bus.io_rdata !== 32'h30) begin n_err++; $display("FAIL entry_count3: got %h expected %h", u_bus.io_rdata, 32'h30); end
         end
      end
      n_cmp++;
      if (disp_data !== 32'h1234_5678) begin n_err++; $display("FAIL entry_word: got %h expected %h", disp_data, 32'h1234_5678); end
      bus_op(1'b0, 1'b1, 8'h08, 32'h0);
      n_cmp++;
      if (u_bus.io_rdata !== 32'h01) begin n_err++; $display("FAIL entry_done: got %h expected %h", u_bus.io_rdata, 32'h01); end
      bus_op(1'b0, 1'b1, 8'h08, 32'h0);
      n_cmp++;
      if (u_bus.io_rdata !== 32'h00) begin n_err++; $display("FAIL entry_done_clr: got %h expected %h", u_bus.io_rdata, 32'h00); end
   endtask

   task automatic test_bounce();
      logic [3:0] d;
      d   = 4'($urandom_range(1, 15));
      sw  = d;
      btn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) btn = ~btn;
         cyc();
      end
      btn = 1'b1;
      repeat (10) cyc();
      btn = 1'b0;
      repeat (DBI + 8) cyc();
      model_press(d);
      n_cmp++;
      if (disp_data !== m_data) begin n_err++; $display("FAIL bounce_disp: got %h expected %h", disp_data, m_data); end
      bus_op(1'b0, 1'b1, 8'h08, 32'h0);
      n_cmp++;
      if (u_bus.io_rdata !== m_rdata) begin n_err++; $display("FAIL bounce_status: got %h expected %h", u_bus.io_rdata, m_rdata); end
   endtask

   task automatic test_collision();
      clean_press(4'h9);
      sw  = 4'h7;
      btn = 1'b1;
      repeat (2) cyc();
      for (int i = 0; i < DBI + 6; i++) bus_op(1'b1, 1'b0, 8'h00, 32'hFFFF_0000);
      btn = 1'b0;
      repeat (DBI + 8) cyc();
      n_cmp++;
      if (disp_data !== 32'hFFFF_0000) begin n_err++; $display("FAIL collide_disp: got %h expected %h", disp_data, 32'hFFFF_0000); end
      bus_op(1'b0, 1'b1, 8'h08, 32'h0);
      n_cmp++;
      if (u_bus.io_rdata !== 32'h0) begin n_err++; $display("FAIL collide_count: got %h expected %h", u_bus.io_rdata, 32'h0); end
   endtask
`endif

   task automatic test_reset_mid();
      bus_op(1'b1, 1'b0, 8'h00, 32'h8765_4321);
      bus_op(1'b1, 1'b0, 8'h04, 32'h1);
      bus_op(1'b0, 1'b1, 8'h00, 32'h0);
      sw  = 4'hE;
      btn = 1'b1;
      repeat (4) cyc();
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (disp_data !== 32'h0) begin n_err++; $display("FAIL midrst_disp: got %h expected %h", disp_data, 32'h0); end
      n_cmp++;
      if (u_bus.io_rdata !== 32'h0) begin n_err++; $display("FAIL midrst_rdata: got %h expected %h", u_bus.io_rdata, 32'h0); end
      model_reset();
      cyc();
      rst = 1'b0;
      repeat (DBI + 8) cyc();
      btn = 1'b0;
      repeat (DBI + 8) cyc();
      n_cmp++;
      if (disp_data !== 32'h0) begin n_err++; $display("FAIL midrst_noshift: got %h expected %h", disp_data, 32'h0); end
      bus_op(1'b0, 1'b1, 8'h08, 32'h0);
      n_cmp++;
      if (u_bus.io_rdata !== 32'h0) begin n_err++; $display("FAIL midrst_status: got %h expected %h", u_bus.io_rdata, 32'h0); end
      bus_op(1'b0, 1'b1, 8'h04, 32'h0);
      n_cmp++;
      if (u_bus.io_rdata !== 32'h0) begin n_err++; $display("FAIL midrst_ctrl: got %h expected %h", u_bus.io_rdata, 32'h0); end
   endtask

   initial begin
      test_reset();
      test_bus();
      test_simultaneous();
      test_random_bus();
      test_ignore();
`ifdef DISP_ENTRY_EN
      test_entry();
      test_bounce();
      test_collision();
`endif
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
